// File: rtl/calc_pkg.sv
// Shared opcode encodings and FSM state type for the sequential opcode calculator.
package calc_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ZERO = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_NOTA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_DIVU = OPC_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Shared shift register + counter: shift-add signed multiply (on magnitudes) and restoring divide.
// One iteration per step, WIDTH steps; res shows the post-step value so the last step's result loads directly. Divider built only with CALC_DIV_EN.
module calc_iter_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               mode,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] sr;
  logic [2*WIDTH-1:0] sr_nxt;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     acc_sum;
  logic               neg;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Multiply: {acc, multiplier} shifts right; acc gains the multiplicand when the low bit is set.
  assign acc_sum = {1'b0, sr[2*WIDTH-1:WIDTH]} + (sr[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {acc_sum, sr[WIDTH-1:1]};

  assign done = step && (cnt == CW'(WIDTH-1));

`ifdef CALC_DIV_EN
  logic               mode_q;
  logic [WIDTH:0]     rem_ext;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_nxt;

  // Divide: {rem, dividend} shifts left; the partial remainder needs one extra bit.
  assign rem_ext = sr[2*WIDTH-1:WIDTH-1];
  assign rem_ge  = rem_ext >= {1'b0, opnd};
  assign rem_new = rem_ge ? WIDTH'(rem_ext - {1'b0, opnd}) : rem_ext[WIDTH-1:0];
  assign div_nxt = {rem_new, sr[WIDTH-2:0], rem_ge};

  assign sr_nxt = mode_q ? div_nxt : mul_nxt;
  assign res    = mode_q ? div_nxt : (neg ? -mul_nxt : mul_nxt);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign sr_nxt      = mul_nxt;
  assign res         = neg ? -mul_nxt : mul_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      opnd   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
`ifdef CALC_DIV_EN
      mode_q <= 1'b0;
`endif
    end else if (load) begin
      cnt <= '0;
`ifdef CALC_DIV_EN
      mode_q <= mode;
      if (mode) begin
        sr   <= {{WIDTH{1'b0}}, a};
        opnd <= b;
        neg  <= 1'b0;
      end else begin
        sr   <= {{WIDTH{1'b0}}, b_mag};
        opnd <= a_mag;
        neg  <= a[WIDTH-1] ^ b[WIDTH-1];
      end
`else
      sr   <= {{WIDTH{1'b0}}, b_mag};
      opnd <= a_mag;
      neg  <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
    end else if (step) begin
      sr  <= sr_nxt;
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_opcode_calc.sv
// Handshaked opcode calculator: logic/add/sub in 1 cycle, MUL (and DIVU with CALC_DIV_EN) in WIDTH+1 cycles.
// ready_o drops while iterating; start_i is ignored, not queued, when ready_o is low.
module seq_opcode_calc
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [OPC_W-1:0]   opcode_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ovf_o,
  output logic               dz_o,
  output logic               illegal_o
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               go_mul;
  logic               go_div;
  logic               iter_load;
  logic               iter_step;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_res;
  logic [2*WIDTH-1:0] alu_res;
  logic [2*WIDTH-1:0] result_q;
  logic               alu_ovf;
  logic               alu_ill;
  logic               ovf_q;
  logic               ill_q;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;

  // Exact (WIDTH+1)-bit signed sum/difference; overflow when the top two bits disagree.
  assign add_ext = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
  assign sub_ext = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};

`ifdef CALC_DIV_EN
  logic alu_dz;
  logic dz_q;
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    go_mul  = 1'b0;
    go_div  = 1'b0;
`ifdef CALC_DIV_EN
    alu_dz  = 1'b0;
`endif
    case (opcode_i)
      OP_ZERO: alu_res = '0;
      OP_NOTA: alu_res[WIDTH-1:0] = ~a_i;
      OP_AND:  alu_res[WIDTH-1:0] = a_i & b_i;
      OP_OR:   alu_res[WIDTH-1:0] = a_i | b_i;
      OP_XOR:  alu_res[WIDTH-1:0] = a_i ^ b_i;
      OP_ADD: begin
        alu_res = {{(WIDTH-1){add_ext[WIDTH]}}, add_ext};
        alu_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = {{(WIDTH-1){sub_ext[WIDTH]}}, sub_ext};
        alu_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
      end
      OP_MUL: go_mul = 1'b1;
`ifdef CALC_DIV_EN
      OP_DIVU: begin
        if (b_i == '0) begin
          alu_res = {a_i, {WIDTH{1'b1}}};
          alu_dz  = 1'b1;
        end else begin
          go_div = 1'b1;
        end
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    iter_step = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        ready_o = 1'b1;
        valid_o = (state == ST_DONE);
        accept  = start_i;
        if (start_i) begin
          state_nxt = go_mul ? ST_MUL : (go_div ? ST_DIV : ST_DONE);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
`ifdef CALC_DIV_EN
      ST_MUL, ST_DIV: begin
`else
      ST_MUL: begin
`endif
        iter_step = 1'b1;
        if (iter_done) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign iter_load = accept && (go_mul || go_div);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  calc_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .load  (iter_load),
    .mode  (go_div),
    .step  (iter_step),
    .a     (a_i),
    .b     (b_i),
    .done  (iter_done),
    .res   (iter_res)
  );

  // Every completion rewrites all flags, so stale flags never survive.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef CALC_DIV_EN
      dz_q     <= 1'b0;
`endif
    end else if (iter_done) begin
      result_q <= iter_res;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef CALC_DIV_EN
      dz_q     <= 1'b0;
`endif
    end else if (accept && !iter_load) begin
      result_q <= alu_res;
      ovf_q    <= alu_ovf;
      ill_q    <= alu_ill;
`ifdef CALC_DIV_EN
      dz_q     <= alu_dz;
`endif
    end
  end

  assign result_o  = result_q;
  assign ovf_o     = ovf_q;
  assign illegal_o = ill_q;
`ifdef CALC_DIV_EN
  assign dz_o      = dz_q;
`else
  assign dz_o      = 1'b0;
`endif

endmodule

// File: doc/seq_opcode_calc.md
# seq_opcode_calc

Parametrised, handshaked successor to the switch-driven opcode calculator. It takes WIDTH-bit operands and a 4-bit opcode, and executes logic, add and subtract in one cycle. Signed multiply (shift-add) and unsigned divide (restoring) are iterative. Results are registered to 2·WIDTH bits with status flags. It sits between the board input-capture logic and the 7-segment/LED display wrapper, which only consumes result_o and the flags.

## Interface
- WIDTH, 4: operand width; legal 2..16; result width is 2·WIDTH.
- CLK100MHZ  in  1  system clock; all state changes on the rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- start_i  in  1  request; accepted on an edge where start_i && ready_o.
- a_i  in  WIDTH  operand A, two's complement for signed ops.
- b_i  in  WIDTH  operand B.
- opcode_i  in  4  operation select.
- ready_o  out  1  able to accept a request.
- valid_o  out  1  one-cycle pulse; result_o and the flags are new.
- result_o  out  2·WIDTH  registered result, held until the next completion.
- ovf_o  out  1  signed add/sub overflow of WIDTH bits.
- dz_o  out  1  divide by zero.
- illegal_o  out  1  undefined opcode.

## Operation
Opcodes:
- 0 ZERO
- 1 NOT A
- 2 AND
- 3 OR
- 4 XOR
- 5 ADD (signed)
- 6 SUB (signed)
- 7 MUL (signed)
- 8 DIVU (unsigned, conditional)
- 9–15 illegal

Operand capture: a_i, b_i and opcode_i are latched on acceptance. Later changes to the inputs have no effect.

Width rules:
- Logic ops: WIDTH-bit result, zero-extended.
- ADD/SUB: exact (WIDTH+1)-bit result, sign-extended to 2·WIDTH. ovf_o=1 when the exact result is outside the signed WIDTH-bit range.
- MUL: exact signed 2·WIDTH product, computed by multiplying magnitudes and negating the product when the operand signs differ. ovf_o=0.
- DIVU: quotient in result_o[WIDTH-1:0], remainder in result_o[2·WIDTH-1:WIDTH].
- DIVU with b=0: quotient all-ones, remainder = A, dz_o=1, no iteration.
- Illegal opcode: result_o=0, illegal_o=1.
- Each completion clears any flag it does not set.

FSM states:
- IDLE: ready_o=1.
  - Accepting a single-cycle op (including illegal and divide-by-zero) → DONE.
  - Accepting MUL → MUL.
  - Accepting DIVU → DIV.
- MUL / DIV: ready_o=0. An iteration counter runs 0..WIDTH-1. When count = WIDTH-1 → DONE, with result and flags loaded on that edge.
- DONE: valid_o=1, ready_o=1.
  - Accept → next state chosen as from IDLE (back-to-back operation).
  - No accept → IDLE.

start_i while ready_o=0 is ignored. It is not queued.

## Timing
- Accept edge is cycle 0.
- Single-cycle ops: valid_o high in cycle 1.
- MUL and DIVU: valid_o high in cycle WIDTH+1. ready_o is low in cycles 1..WIDTH.
- Sustained throughput for single-cycle ops: one result per cycle.
- Reset values (async assertion, held while CPU_RESETN=0):
  - state IDLE, ready_o=1
  - valid_o=0, result_o=0, ovf_o=dz_o=illegal_o=0
  - counter 0
- Reset mid-iteration aborts the operation. No valid_o is ever produced for the aborted request.
- Release is synchronised by the board wrapper. The block is ready in the first cycle after release.

## Configuration
- CALC_DIV_EN defined: opcode 8 is DIVU as above, and the DIV state and divider datapath are built.
- CALC_DIV_EN undefined: the DIV state and datapath are removed. Opcode 8 is illegal (result 0, illegal_o=1, latency 1), and dz_o is tied 0.

## Structure
- Package calc_pkg holds:
  - opcode localparams (OP_ZERO..OP_DIVU)
  - FSM state enum (ST_IDLE, ST_MUL, ST_DIV, ST_DONE)
  - opcode width constant (4)
- One sub-module, calc_iter_unit: shared shift register and counter for shift-add multiply and restoring divide.
  - Controls: WIDTH parameter, load/mode/step in.
  - Outputs: done and product/quotient/remainder.
- Top-level FSM, single-cycle ALU, result and flag registers stay in seq_opcode_calc.

## Test plan
All with WIDTH=4.
- ADD a=0x7, b=0x1 → valid_o in cycle 1, result_o=0x08, ovf_o=1. Then SUB a=0x8, b=0x1 → result_o=0xF7, ovf_o=1.
- MUL a=0x8 (−8), b=0x8 (−8) → result_o=0x40 exactly in cycle 5, ready_o low cycles 1–4. MUL a=0x3, b=0xE → result_o=0xFA.
- DIVU a=13, b=4 (CALC_DIV_EN defined) → result_o=0x13, valid_o in cycle 5. DIVU a=0xD, b=0 → result_o=0xDF, dz_o=1, valid_o in cycle 1.
- start_i held high during MUL with different operands → ignored. A new XOR a=0xA, b=0x6 issued in the DONE cycle → accepted, result_o=0x0C in the next cycle.
- CPU_RESETN pulsed low in cycle 2 of a MUL → no valid_o, result_o=0, ready_o=1 after release.
- CALC_DIV_EN undefined, opcode 8 (and opcode 12 in either build) → result_o=0x00, illegal_o=1, dz_o=0, latency 1.
